// File: rtl/risc_cpu_pkg.sv
// risc_cpu_pkg
// Shared definitions for the parametrised accumulator CPU:
//   - 3-bit opcode constants
//   - FSM state enum (IDLE, FETCH, DECODE, EXEC, HALT)
//   - ALU operation select codes
//   - helper telling which opcodes need a second memory access
package risc_cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_STA = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_NEG = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_SUB  = 2'd2;
    localparam logic [1:0] ALU_NEG  = 2'd3;

    // Opcodes that touch memory a second time (operand access in EXEC).
    function automatic logic needs_exec(input logic [2:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/risc_alu.sv
// risc_alu
// Combinational DATA_W-wide ALU for the accumulator CPU.
// Ports:
//   op  in  2       operation select (ALU_PASS/ADD/SUB/NEG)
//   a   in  DATA_W  accumulator operand
//   b   in  DATA_W  memory operand
//   y   out DATA_W  result, modulo 2^DATA_W
//   co  out 1       carry out (ADD) or unsigned borrow (SUB); 0 otherwise
module risc_alu
    import risc_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic              co
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    always_comb begin
        y  = b;
        co = 1'b0;
        case (op)
            ALU_ADD: {co, y} = {1'b0, a} + {1'b0, b};
            ALU_SUB: begin
                y  = a - b;
                co = (b > a);
            end
            ALU_NEG: y = ~a + ONE;
            default: y = b;
        endcase
    end

endmodule

// File: rtl/risc_cpu_param.sv
// risc_cpu_param
// Parametrised accumulator CPU core driving a single-port memory with a
// mem_ready wait-state handshake.
// Ports:
//   clk        in   1       system clock, rising edge
//   clr        in   1       asynchronous active-high reset
//   read       out  1       memory read request
//   write      out  1       memory write request
//   address    out  ADDR_W  memory address
//   memoryOut  in   DATA_W  read data (combinational from address)
//   memoryIn   out  DATA_W  write data, always the accumulator
//   mem_ready  in   1       access completes on an edge with mem_ready=1
//   acc        out  DATA_W  accumulator
//   carry      out  1       carry/borrow flag
//   halted     out  1       core is in HALT
module risc_cpu_param
    import risc_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] memoryOut,
    output logic [DATA_W-1:0] memoryIn,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              halted
);

    if (DATA_W < ADDR_W + 3) begin : g_bad_params
        $error("risc_cpu_param: DATA_W must be at least ADDR_W+3");
    end

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] acc_r;
    logic              c_r;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] opa;
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;

    assign opcode = ir[DATA_W-1 -: 3];
    assign opa    = ir[ADDR_W-1:0];

    // Bits between the opcode and operand fields carry no meaning.
    if (DATA_W > ADDR_W + 3) begin : g_gap
        logic unused_ir_gap;
        assign unused_ir_gap = ^ir[DATA_W-4:ADDR_W];
    end

    always_comb begin
        case (opcode)
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_NEG:  alu_op = ALU_NEG;
            default: alu_op = ALU_PASS;
        endcase
    end

    risc_alu #(.DATA_W(DATA_W)) u_alu (
        .op (alu_op),
        .a  (acc_r),
        .b  (memoryOut),
        .y  (alu_y),
        .co (alu_c)
    );

    // Bus outputs are a pure decode of state and IR, so an asynchronous
    // clr drops read/write immediately with the state register.
    always_comb begin
        read    = 1'b0;
        write   = 1'b0;
        address = pc;
        halted  = 1'b0;
        case (state)
            FETCH: read = 1'b1;
            EXEC: begin
                address = opa;
                if (opcode == OP_STA) write = 1'b1;
                else                  read  = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    assign memoryIn = acc_r;
    assign acc      = acc_r;
    assign carry    = c_r;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
            acc_r <= '0;
            c_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (mem_ready) begin
                        ir    <= memoryOut;
                        pc    <= pc + PC_ONE;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (opcode == OP_HLT) begin
                        state <= HALT;
                    end else if (needs_exec(opcode)) begin
                        state <= EXEC;
                    end else begin
                        // JMP, JZ and NEG complete without a memory access.
                        if (opcode == OP_JMP) pc <= opa;
                        if (opcode == OP_JZ && acc_r == '0) pc <= opa;
                        if (opcode == OP_NEG) acc_r <= alu_y;
                        state <= FETCH;
                    end
                end
                EXEC: begin
                    if (mem_ready) begin
                        // STA's data is taken by memory on this same edge.
                        if (opcode != OP_STA) acc_r <= alu_y;
                        if (opcode == OP_ADD || opcode == OP_SUB) c_r <= alu_c;
                        state <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
